// File: rtl/beta_exe_lsu.sv
// ---------------------------------------------------------------------------
// beta_exe_lsu -- Load & Store Unit of the exe stage.
//
// Accepts one load/store request from the exe-stage control unit, turns it
// into a single transaction on an OBI-style data-memory port, and returns
// aligned, sign/zero-extended load data to the exe result mux.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   lsu_en_i              request strobe (sampled only when idle)
//   lsu_op_i              0 = load, 1 = store
//   lsu_op_size_i         00 byte, 01 half, 10 word, 11 illegal
//   lsu_unsigned_i        1 = zero-extend load data, 0 = sign-extend
//   lsu_addr_i            effective byte address
//   lsu_wdata_i           store data, LSB-aligned
//   lsu_busy_o            operation in progress
//   lsu_rdata_o           formatted load result (held until next load)
//   lsu_done_o            one-cycle completion pulse
//   lsu_misaligned_o      one-cycle pulse on misaligned/illegal request
//   data_req_o .. data_wdata_o   memory request side
//   data_gnt_i, data_rvalid_i, data_rdata_i   memory response side
// ---------------------------------------------------------------------------
module beta_exe_lsu #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 lsu_en_i,
    input  logic                 lsu_op_i,
    input  logic [1:0]           lsu_op_size_i,
    input  logic                 lsu_unsigned_i,
    input  logic [DataWidth-1:0] lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 lsu_busy_o,
    output logic [DataWidth-1:0] lsu_rdata_o,
    output logic                 lsu_done_o,
    output logic                 lsu_misaligned_o,
    output logic                 data_req_o,
    output logic [DataWidth-1:0] data_addr_o,
    output logic                 data_we_o,
    output logic [3:0]           data_be_o,
    output logic [DataWidth-1:0] data_wdata_o,
    input  logic                 data_gnt_i,
    input  logic                 data_rvalid_i,
    input  logic [DataWidth-1:0] data_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic                 r_op;
    logic [1:0]           r_size;
    logic                 r_unsigned;
    logic [DataWidth-1:0] r_addr;
    logic [DataWidth-1:0] r_wdata;
    logic [DataWidth-1:0] r_rdata;

    logic [3:0]           w_be;
    logic [DataWidth-1:0] w_lane_wdata;
    logic [DataWidth-1:0] w_load_fmt;

    // Size 11 is never legal; half needs an even address, word a 4-aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic res;
        case (size)
            2'b00:   res = 1'b0;
            2'b01:   res = off[0];
            2'b10:   res = (off != 2'b00);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = 4'b0011 << {off[1], 1'b0};
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store data across all lanes so the byte enables alone
    // select which bytes memory writes.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] res;
        case (size)
            2'b00:   res = {4{wd[7:0]}};
            2'b01:   res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    // Shift the addressed lane down to bit 0, then extend to 32 bits.
    function automatic logic [31:0] format_load(input logic [31:0] rd, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
        logic        [31:0] sh;
        logic signed [7:0]  sh_b;
        logic signed [15:0] sh_h;
        logic signed [31:0] sext;
        logic        [31:0] res;
        sh   = rd >> {off, 3'b000};
        sh_b = signed'(sh[7:0]);
        sh_h = signed'(sh[15:0]);
        case (size)
            2'b00: begin
                sext = 32'(sh_b);
                res  = uns ? {24'd0, sh[7:0]} : unsigned'(sext);
            end
            2'b01: begin
                sext = 32'(sh_h);
                res  = uns ? {16'd0, sh[15:0]} : unsigned'(sext);
            end
            default: begin
                sext = signed'(sh);
                res  = sh;
            end
        endcase
        return res;
    endfunction

    assign w_be         = byte_enable(r_size, r_addr[1:0]);
    assign w_lane_wdata = lane_wdata(r_size, r_wdata);
    assign w_load_fmt   = format_load(data_rdata_i, r_size, r_addr[1:0], r_unsigned);

    // State register, request capture and load-result register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_WAIT && data_rvalid_i && !r_op) begin
                r_rdata <= w_load_fmt;
            end
        end
    end

    // Request fields carry no control meaning on their own, so they are
    // captured without reset; every output that uses them is state-gated.
    always_ff @(posedge clk_i) begin
        if (r_state == S_IDLE && lsu_en_i) begin
            r_op       <= lsu_op_i;
            r_size     <= lsu_op_size_i;
            r_unsigned <= lsu_unsigned_i;
            r_addr     <= lsu_addr_i;
            r_wdata    <= lsu_wdata_i;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (lsu_en_i) begin
                    w_next = is_misaligned(lsu_op_size_i, lsu_addr_i[1:0]) ? S_ERR : S_REQ;
                end
            end
            S_REQ:   if (data_gnt_i)    w_next = S_WAIT;
            S_WAIT:  if (data_rvalid_i) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state, so busy rises the
    // cycle after the request is sampled and everything is 0 out of reset.
    always_comb begin
        lsu_busy_o       = (r_state == S_REQ) || (r_state == S_WAIT) || (r_state == S_ERR);
        lsu_done_o       = (r_state == S_DONE);
        lsu_misaligned_o = (r_state == S_ERR);
        data_req_o       = (r_state == S_REQ);
        data_addr_o      = '0;
        data_we_o        = 1'b0;
        data_be_o        = 4'b0000;
        data_wdata_o     = '0;
        if (r_state == S_REQ) begin
            data_addr_o  = {r_addr[DataWidth-1:2], 2'b00};
            data_we_o    = r_op;
            data_be_o    = w_be;
            data_wdata_o = w_lane_wdata;
        end
    end

    assign lsu_rdata_o = r_rdata;

endmodule

// File: tb/tb_beta_exe_lsu.sv
module tb_beta_exe_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        lsu_en_i;
    logic        lsu_op_i;
    logic [1:0]  lsu_op_size_i;
    logic        lsu_unsigned_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_busy_o;
    logic [31:0] lsu_rdata_o;
    logic        lsu_done_o;
    logic        lsu_misaligned_o;
    logic        data_req_o;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;

    always #5 clk_i = ~clk_i;

    beta_exe_lsu #(.DataWidth(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .lsu_en_i(lsu_en_i), .lsu_op_i(lsu_op_i), .lsu_op_size_i(lsu_op_size_i),
        .lsu_unsigned_i(lsu_unsigned_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_busy_o(lsu_busy_o), .lsu_rdata_o(lsu_rdata_o), .lsu_done_o(lsu_done_o),
        .lsu_misaligned_o(lsu_misaligned_o),
        .data_req_o(data_req_o), .data_addr_o(data_addr_o), .data_we_o(data_we_o),
        .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
        .data_gnt_i(data_gnt_i), .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_rd;

    // Observations of one operation, cycle 0 = cycle en is presented
    int          o_req, o_busy, o_busy_first, o_done, o_done_cyc, o_mis, o_mis_cyc;
    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    logic        o_we;
    bit          o_stable, o_timeout;

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'b10) return 4'b1111;
        if (size == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
        case (off)
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wd);
        if (size == 2'b00) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (size == 2'b01) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [31:0] mem, input logic [1:0] size,
                                            input logic [1:0] off, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = mem[8*off +: 8];
        h = off[1] ? mem[31:16] : mem[15:0];
        if (size == 2'b00) return uns ? {24'd0, b} : {{24{b[7]}}, b};
        if (size == 2'b01) return uns ? {16'd0, h} : {{16{h[15]}}, h};
        return mem;
    endfunction

    // Drives one request and plays the memory side; gnt arrives after
    // gnt_delay stalled REQ cycles, rvalid the cycle after gnt.
    task automatic run_op(input logic op, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] mem, input int gnt_delay);
        bit finished;
        finished = 0;
        o_req = 0; o_busy = 0; o_busy_first = -1; o_done = 0; o_done_cyc = -1;
        o_mis = 0; o_mis_cyc = -1; o_stable = 1; o_timeout = 0;
        o_addr = '0; o_wdata = '0; o_rdata = '0; o_be = '0; o_we = 1'b0;
        lsu_en_i = 1'b1; lsu_op_i = op; lsu_op_size_i = size; lsu_unsigned_i = uns;
        lsu_addr_i = addr; lsu_wdata_i = wdata; data_rdata_i = mem;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk_i); #1;
            if (cyc == 1) lsu_en_i = 1'b0;
            data_rvalid_i = data_gnt_i;
            if (data_req_o) begin
                if (o_req == 0) begin
                    o_addr = data_addr_o; o_be = data_be_o; o_we = data_we_o; o_wdata = data_wdata_o;
                end else if (data_addr_o !== o_addr || data_be_o !== o_be ||
                             data_we_o !== o_we || data_wdata_o !== o_wdata) begin
                    o_stable = 0;
                end
                o_req++;
            end
            data_gnt_i = data_req_o && (o_req > gnt_delay);
            if (lsu_busy_o) begin
                if (o_busy_first < 0) o_busy_first = cyc;
                o_busy++;
            end
            if (lsu_done_o) begin o_done++; o_done_cyc = cyc; o_rdata = lsu_rdata_o; end
            if (lsu_misaligned_o) begin o_mis++; o_mis_cyc = cyc; end
            if ((o_done > 0 || o_mis > 0) && !lsu_done_o && !lsu_misaligned_o && !lsu_busy_o) begin
                finished = 1;
                break;
            end
        end
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0;
        if (!finished) o_timeout = 1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if ({lsu_busy_o, lsu_done_o, lsu_misaligned_o, data_req_o, data_we_o} !== 5'b0) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000", {lsu_busy_o, lsu_done_o, lsu_misaligned_o, data_req_o, data_we_o}); end
        checks++; if (lsu_rdata_o !== 32'h0 || data_addr_o !== 32'h0 || data_be_o !== 4'h0 || data_wdata_o !== 32'h0) begin errors++; $display("FAIL reset_data: rdata %h addr %h be %h wdata %h expected all 0", lsu_rdata_o, data_addr_o, data_be_o, data_wdata_o); end
        rst_i = 1'b0;
        model_rd = 32'h0;
    endtask

    task automatic test_load_word;
        exp_t e;
        sb.push_back('{addr: 32'h100, be: 4'b1111, we: 1'b0, wdata: 32'h0, rdata: 32'hDEADBEEF});
        model_rd = 32'hDEADBEEF;
        run_op(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
        e = sb.pop_front();
        checks++; if (o_timeout) begin errors++; $display("FAIL lw_timeout: operation did not complete"); end
        checks++; if (o_addr !== e.addr || o_be !== e.be || o_we !== e.we) begin errors++; $display("FAIL lw_req: addr %h be %b we %b expected %h %b %b", o_addr, o_be, o_we, e.addr, e.be, e.we); end
        checks++; if (o_rdata !== e.rdata) begin errors++; $display("FAIL lw_rdata: got %h expected %h", o_rdata, e.rdata); end
        checks++; if (o_done != 1 || o_done_cyc != 3) begin errors++; $display("FAIL lw_done: count %0d cycle %0d expected 1 at 3", o_done, o_done_cyc); end
        checks++; if (o_busy_first != 1 || o_busy != 2 || o_req != 1) begin errors++; $display("FAIL lw_busy: first %0d count %0d req %0d expected 1 2 1", o_busy_first, o_busy, o_req); end
    endtask

    task automatic test_load_byte;
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            sb.push_back('{addr: 32'h100, be: 4'b1000, we: 1'b0, wdata: 32'h0,
                           rdata: (u == 1) ? 32'h00000080 : 32'hFFFFFF80});
            run_op(1'b0, 2'b00, u[0], 32'h103, 32'h0, 32'h80123456, 0);
            e = sb.pop_front();
            model_rd = e.rdata;
            checks++; if (o_addr !== e.addr || o_be !== e.be || o_done != 1) begin errors++; $display("FAIL lb_req u=%0d: addr %h be %b done %0d expected %h %b 1", u, o_addr, o_be, o_done, e.addr, e.be); end
            checks++; if (o_rdata !== e.rdata) begin errors++; $display("FAIL lb_rdata u=%0d: got %h expected %h", u, o_rdata, e.rdata); end
        end
    endtask

    task automatic test_store_half;
        exp_t e;
        sb.push_back('{addr: 32'h20, be: 4'b1100, we: 1'b1, wdata: 32'hABCDABCD, rdata: model_rd});
        run_op(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'h55555555, 0);
        e = sb.pop_front();
        checks++; if (o_addr !== e.addr || o_be !== e.be || o_we !== e.we) begin errors++; $display("FAIL sh_req: addr %h be %b we %b expected %h %b %b", o_addr, o_be, o_we, e.addr, e.be, e.we); end
        checks++; if (o_wdata !== e.wdata) begin errors++; $display("FAIL sh_wdata: got %h expected %h", o_wdata, e.wdata); end
        checks++; if (o_rdata !== e.rdata || o_done != 1) begin errors++; $display("FAIL sh_rdata_kept: got %h done %0d expected %h 1", o_rdata, o_done, e.rdata); end
    endtask

    task automatic test_gnt_stall;
        exp_t e;
        sb.push_back('{addr: 32'h200, be: 4'b1111, we: 1'b0, wdata: 32'h0, rdata: 32'h0BADF00D});
        model_rd = 32'h0BADF00D;
        run_op(1'b0, 2'b10, 1'b1, 32'h200, 32'h0, 32'h0BADF00D, 3);
        e = sb.pop_front();
        checks++; if (o_req != 4 || !o_stable) begin errors++; $display("FAIL stall_req: req cycles %0d stable %0d expected 4 1", o_req, o_stable); end
        checks++; if (o_addr !== e.addr || o_be !== e.be) begin errors++; $display("FAIL stall_addr: addr %h be %b expected %h %b", o_addr, o_be, e.addr, e.be); end
        checks++; if (o_busy != 5 || o_done_cyc != 6) begin errors++; $display("FAIL stall_busy: busy %0d done cycle %0d expected 5 6", o_busy, o_done_cyc); end
        checks++; if (o_rdata !== e.rdata) begin errors++; $display("FAIL stall_rdata: got %h expected %h", o_rdata, e.rdata); end
    endtask

    task automatic test_misaligned;
        logic [1:0]  sz [2];
        logic [31:0] ad [2];
        sz[0] = 2'b10; ad[0] = 32'h102;
        sz[1] = 2'b11; ad[1] = 32'h100;
        for (int k = 0; k < 2; k++) begin
            run_op(1'b0, sz[k], 1'b0, ad[k], 32'h0, 32'h0, 0);
            checks++; if (o_req != 0) begin errors++; $display("FAIL mis%0d_req: req cycles %0d expected 0", k, o_req); end
            checks++; if (o_mis != 1 || o_mis_cyc != 1) begin errors++; $display("FAIL mis%0d_pulse: count %0d cycle %0d expected 1 at 1", k, o_mis, o_mis_cyc); end
            checks++; if (o_busy != 1 || o_done != 0) begin errors++; $display("FAIL mis%0d_busy: busy %0d done %0d expected 1 0", k, o_busy, o_done); end
            checks++; if (lsu_rdata_o !== model_rd) begin errors++; $display("FAIL mis%0d_rdata: got %h expected %h", k, lsu_rdata_o, model_rd); end
        end
    endtask

    task automatic test_reset_mid;
        int dones;
        dones = 0;
        lsu_en_i = 1'b1; lsu_op_i = 1'b0; lsu_op_size_i = 2'b10; lsu_unsigned_i = 1'b0;
        lsu_addr_i = 32'h300; lsu_wdata_i = 32'h0; data_rdata_i = 32'hCAFEBABE;
        @(posedge clk_i); #1;
        lsu_en_i = 1'b0;
        checks++; if (data_req_o !== 1'b1) begin errors++; $display("FAIL rstmid_req: got %b expected 1", data_req_o); end
        data_gnt_i = 1'b1;
        @(posedge clk_i); #1;
        data_gnt_i = 1'b0;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        data_rvalid_i = 1'b1;
        checks++; if (lsu_busy_o !== 1'b0 || data_req_o !== 1'b0) begin errors++; $display("FAIL rstmid_idle: busy %b req %b expected 0 0", lsu_busy_o, data_req_o); end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i); #1;
            data_rvalid_i = 1'b0;
            if (lsu_done_o) dones++;
        end
        model_rd = 32'h0;
        checks++; if (dones != 0 || lsu_busy_o !== 1'b0) begin errors++; $display("FAIL rstmid_done: done pulses %0d busy %b expected 0 0", dones, lsu_busy_o); end
        checks++; if (lsu_rdata_o !== 32'h0) begin errors++; $display("FAIL rstmid_rdata: got %h expected 00000000", lsu_rdata_o); end
    endtask

    task automatic test_random;
        exp_t        e;
        logic        op, uns;
        logic [1:0]  size;
        logic [31:0] addr, wdata, mem;
        for (int n = 0; n < 12; n++) begin
            op    = 1'($urandom_range(0, 1));
            uns   = 1'($urandom_range(0, 1));
            size  = 2'($urandom_range(0, 2));
            addr  = $urandom;
            if (size == 2'b10) addr[1:0] = 2'b00;
            if (size == 2'b01) addr[0] = 1'b0;
            wdata = $urandom;
            mem   = $urandom;
            if (!op) model_rd = m_rdata(mem, size, addr[1:0], uns);
            sb.push_back('{addr: {addr[31:2], 2'b00}, be: m_be(size, addr[1:0]), we: op,
                           wdata: m_wdata(size, wdata), rdata: model_rd});
            run_op(op, size, uns, addr, wdata, mem, int'($urandom_range(0, 2)));
            e = sb.pop_front();
            checks++; if (o_addr !== e.addr || o_be !== e.be || o_we !== e.we || o_done != 1) begin errors++; $display("FAIL rnd%0d_req: addr %h be %b we %b done %0d expected %h %b %b 1", n, o_addr, o_be, o_we, o_done, e.addr, e.be, e.we); end
            if (op) begin
                checks++; if (o_wdata !== e.wdata) begin errors++; $display("FAIL rnd%0d_wdata: got %h expected %h", n, o_wdata, e.wdata); end
            end
            checks++; if (o_rdata !== e.rdata) begin errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", n, o_rdata, e.rdata); end
        end
    endtask

    initial begin
        rst_i = 1'b1; lsu_en_i = 1'b0; lsu_op_i = 1'b0; lsu_op_size_i = 2'b00;
        lsu_unsigned_i = 1'b0; lsu_addr_i = '0; lsu_wdata_i = '0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        test_reset();
        test_load_word();
        test_load_byte();
        test_store_half();
        test_gnt_stall();
        test_misaligned();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/beta_exe_lsu.md
Name: beta_exe_lsu

Overview:
Load & Store Unit of the exe stage. It is driven by the exe-stage control unit through en/op/size and reports back through busy. Each accepted request is turned into a single data-memory transaction on an OBI-style req/gnt/rvalid port. Load data is aligned and sign- or zero-extended before being returned to the exe result mux.

Parameters:
DataWidth, 32, data and address width; only 32 is supported.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
lsu_en_i  in  1  request strobe from exe CU; sampled only in IDLE
lsu_op_i  in  1  0 = load, 1 = store
lsu_op_size_i  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
lsu_unsigned_i  in  1  1 = zero-extend load data, 0 = sign-extend
lsu_addr_i  in  DataWidth  effective byte address (rs1 + imm)
lsu_wdata_i  in  DataWidth  store data (rs2), LSB-aligned
lsu_busy_o  out  1  operation in progress
lsu_rdata_o  out  DataWidth  formatted load result
lsu_done_o  out  1  one-cycle pulse when the operation completes
lsu_misaligned_o  out  1  one-cycle pulse on a misaligned or illegal-size request
data_req_o  out  1  memory request
data_addr_o  out  DataWidth  word-aligned address, {addr[31:2], 2'b00}
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  DataWidth  lane-replicated store data
data_gnt_i  in  1  request accepted
data_rvalid_i  in  1  response valid; also asserted for stores
data_rdata_i  in  DataWidth  read data

Behaviour:
- Reset (rst_i = 1 at a clk_i edge):
  - FSM goes to IDLE.
  - All outputs go to 0; lsu_rdata_o = 0.
  - An aborted outstanding transaction's rvalid is ignored.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - When lsu_en_i = 1, latch op, size, unsigned, addr and wdata into internal registers.
  - Misaligned request goes to ERR. Misaligned means: half with addr[0] = 1; word with addr[1:0] != 0; size 11 always.
  - Otherwise go to REQ.
  - lsu_busy_o is registered and rises the cycle after lsu_en_i is sampled.
- REQ:
  - data_req_o = 1, with addr/we/be/wdata driven from the latched registers and held stable until granted.
  - data_gnt_i = 1 moves to WAIT; otherwise stay in REQ.
- WAIT:
  - data_req_o = 0.
  - data_rvalid_i = 1 captures the formatted rdata into lsu_rdata_o (loads only; stores leave it unchanged) and moves to DONE.
  - rvalid is guaranteed no earlier than the cycle after gnt; rvalid seen in REQ/IDLE is ignored.
- DONE:
  - lsu_done_o = 1 and lsu_busy_o = 0 for one cycle, then go to IDLE.
  - lsu_en_i is ignored in DONE.
- ERR:
  - lsu_misaligned_o = 1 and lsu_busy_o = 1 for one cycle, with no memory request.
  - Then go to IDLE with busy = 0; lsu_done_o stays 0.
- Busy rule: lsu_busy_o = 1 in REQ, WAIT and ERR. Busy is therefore high for at least one cycle per accepted request, as the CU handshake requires.
- lsu_en_i held high while busy has no effect. After DONE, a still-high lsu_en_i re-launches from IDLE; the CU is responsible for dropping it.
- Byte enables (off = addr[1:0] latched):
  - byte: 4'b0001 << off
  - half: 4'b0011 << {off[1], 1'b0}
  - word: 4'b1111
- Store data lanes:
  - byte: wdata[7:0] replicated ×4
  - half: wdata[15:0] replicated ×2
  - word: unchanged
- Load formatting:
  - sh = data_rdata_i >> (8 * off).
  - byte: extend sh[7:0]; half: extend sh[15:0]; word: sh.
  - Extension is zero when unsigned = 1, sign otherwise.
- Latency with gnt in the first REQ cycle and rvalid the following cycle:
  - en at cycle 0, req at cycles 1–1, rvalid at cycle 2, done/busy low at cycle 3.
- Reset mid-operation: immediate return to IDLE; data_req_o drops in the same edge.

Test Plan:
- Load word: addr 0x100, rdata 0xDEADBEEF, gnt and rvalid with zero wait → data_addr_o 0x100, be 4'b1111, we 0; lsu_rdata_o 0xDEADBEEF; done pulse at cycle 3; busy high for cycles 1–2.
- Load byte signed/unsigned: addr 0x103, rdata 0x80xxxxxx → signed result 0xFFFFFF80, unsigned result 0x00000080; be 4'b1000.
- Store half: addr 0x22, wdata 0x1234ABCD → data_addr_o 0x20, be 4'b1100, data_wdata_o 0xABCDABCD, we 1; lsu_rdata_o unchanged.
- Grant stall: data_gnt_i held low for 3 cycles → req, addr and be stable for 4 cycles; busy stays high until the cycle after rvalid.
- Misaligned: word at 0x102, and separately size 11 → no data_req_o; misaligned pulse of 1 cycle; busy high for exactly 1 cycle; no done pulse.
- Reset in WAIT, then rvalid the next cycle → FSM in IDLE; rvalid ignored; lsu_rdata_o = 0; no done pulse.
